// File: rtl/piso_shift_reg_pkg.sv
// Shared helpers for the parallel-in / serial-out serialiser.
package piso_shift_reg_pkg;

  // Bits needed to hold a bit count from 0 up to and including w.
  function automatic int unsigned cnt_width(input int unsigned w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/piso_shift_reg_if.sv
// Parallel word in, serial bit and status out.
interface piso_shift_reg_if #(
  parameter int unsigned WIDTH = 4
);
  logic             load;
  logic [WIDTH-1:0] parallel_in;
  logic             serial_out;
  logic             serial_valid;
  logic             busy;

  modport master (
    output load, parallel_in,
    input  serial_out, serial_valid, busy
  );

  modport slave (
    input  load, parallel_in,
    output serial_out, serial_valid, busy
  );
endinterface

// File: rtl/piso_bit_counter.sv
// Down-counter of bits remaining in the current word; saturates at zero.
module piso_bit_counter #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned CW    = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic          dec,
  output logic [CW-1:0] count,
  output logic          zero
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      count <= '0;
    else if (load)
      count <= CW'(WIDTH);
    else if (dec && count != '0)
      count <= count - CW'(1);
  end

  assign zero = (count == '0);

endmodule

// File: rtl/piso_shift_reg.sv
// Serialiser: captures a word on load and emits it one bit per clock.
module piso_shift_reg
  import piso_shift_reg_pkg::*;
#(
  parameter int unsigned WIDTH     = 4,
  parameter bit          MSB_FIRST = 1'b1,
  parameter logic        FILL_BIT  = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  piso_shift_reg_if.slave  bus
);

  localparam int unsigned CW = cnt_width(WIDTH);

  logic [WIDTH-1:0] sreg;
  logic [WIDTH-1:0] shifted;
  logic             out_bit;
  logic [CW-1:0]    count;
  logic             zero;

  piso_bit_counter #(
    .WIDTH (WIDTH),
    .CW    (CW)
  ) u_counter (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (bus.load),
    .dec   (!zero),
    .count (count),
    .zero  (zero)
  );

  generate
    if (MSB_FIRST) begin : g_msb_first
      assign shifted = {sreg[WIDTH-2:0], FILL_BIT};
      assign out_bit = sreg[WIDTH-1];
    end else begin : g_lsb_first
      assign shifted = {FILL_BIT, sreg[WIDTH-1:1]};
      assign out_bit = sreg[0];
    end
  endgenerate

  // The final shift of a word fills the register completely with FILL_BIT,
  // so the output end alone gives FILL_BIT once the word is exhausted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      sreg <= {WIDTH{FILL_BIT}};
    else if (bus.load)
      sreg <= bus.parallel_in;
    else if (!zero)
      sreg <= shifted;
  end

  assign bus.serial_out   = out_bit;
  assign bus.serial_valid = !zero;
  assign bus.busy         = (count > CW'(1));

endmodule

// File: tb/tb_piso_shift_reg.sv
// Bench for piso_shift_reg: vector table, directed corner cases, random vs queue model.
module tb_piso_shift_reg;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  piso_shift_reg_if #(.WIDTH(4)) if4 ();
  piso_shift_reg_if #(.WIDTH(8)) if8 ();

  piso_shift_reg #(.WIDTH(4), .MSB_FIRST(1'b1), .FILL_BIT(1'b0)) u_dut4 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if4)
  );

  piso_shift_reg #(.WIDTH(8), .MSB_FIRST(1'b0), .FILL_BIT(1'b0)) u_dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  typedef struct {
    logic       ld;
    logic [3:0] d;
    logic       so;
    logic       sv;
    logic       bz;
  } vec_t;

  vec_t tbl[$];
  bit   q4[$];
  bit   q8[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk4(input string nm, input logic so, input logic sv, input logic bz);
    chk({nm, "_out"},   32'(if4.serial_out),   32'(so));
    chk({nm, "_valid"}, 32'(if4.serial_valid), 32'(sv));
    chk({nm, "_busy"},  32'(if4.busy),         32'(bz));
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    if4.load = 1'b1; if4.parallel_in = 4'hF;
    if8.load = 1'b0; if8.parallel_in = 8'h00;

    // Reset dominates a held load
    tick(); tick();
    chk4("reset", 1'b0, 1'b0, 1'b0);
    chk("reset8_valid", 32'(if8.serial_valid), 32'd0);
    if4.load = 1'b0;
    rst_n = 1'b1;
    tick();
    chk4("post_reset", 1'b0, 1'b0, 1'b0);

    // Basic MSB-first, back-to-back, mid-shift reload
    tbl.push_back('{1'b1, 4'b1101, 1'b1, 1'b1, 1'b1});
    tbl.push_back('{1'b0, 4'b0000, 1'b1, 1'b1, 1'b1});
    tbl.push_back('{1'b0, 4'b0000, 1'b0, 1'b1, 1'b1});
    tbl.push_back('{1'b0, 4'b0000, 1'b1, 1'b1, 1'b0});
    tbl.push_back('{1'b0, 4'b0000, 1'b0, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 4'b0000, 1'b0, 1'b0, 1'b0});
    tbl.push_back('{1'b1, 4'b1010, 1'b1, 1'b1, 1'b1});
    tbl.push_back('{1'b0, 4'b0000, 1'b0, 1'b1, 1'b1});
    tbl.push_back('{1'b0, 4'b0000, 1'b1, 1'b1, 1'b1});
    tbl.push_back('{1'b0, 4'b0000, 1'b0, 1'b1, 1'b0});
    tbl.push_back('{1'b1, 4'b0110, 1'b0, 1'b1, 1'b1});
    tbl.push_back('{1'b0, 4'b0000, 1'b1, 1'b1, 1'b1});
    tbl.push_back('{1'b0, 4'b0000, 1'b1, 1'b1, 1'b1});
    tbl.push_back('{1'b0, 4'b0000, 1'b0, 1'b1, 1'b0});
    tbl.push_back('{1'b0, 4'b0000, 1'b0, 1'b0, 1'b0});
    tbl.push_back('{1'b1, 4'b1111, 1'b1, 1'b1, 1'b1});
    tbl.push_back('{1'b0, 4'b0000, 1'b1, 1'b1, 1'b1});
    tbl.push_back('{1'b1, 4'b0001, 1'b0, 1'b1, 1'b1});
    tbl.push_back('{1'b0, 4'b0000, 1'b0, 1'b1, 1'b1});
    tbl.push_back('{1'b0, 4'b0000, 1'b0, 1'b1, 1'b1});
    tbl.push_back('{1'b0, 4'b0000, 1'b1, 1'b1, 1'b0});
    tbl.push_back('{1'b0, 4'b0000, 1'b0, 1'b0, 1'b0});
    tbl.push_back('{1'b1, 4'b1111, 1'b1, 1'b1, 1'b1});
    tbl.push_back('{1'b1, 4'b1111, 1'b1, 1'b1, 1'b1});
    tbl.push_back('{1'b1, 4'b1111, 1'b1, 1'b1, 1'b1});
    tbl.push_back('{1'b0, 4'b0000, 1'b1, 1'b1, 1'b1});

    for (int i = 0; i < tbl.size(); i++) begin
      if4.load = tbl[i].ld;
      if4.parallel_in = tbl[i].d;
      tick();
      chk4($sformatf("tbl%0d", i), tbl[i].so, tbl[i].sv, tbl[i].bz);
    end
    if4.load = 1'b0;
    tick(); tick(); tick(); tick();
    chk4("tbl_drain", 1'b0, 1'b0, 1'b0);

    // Asynchronous reset while bit 2 is showing
    if4.load = 1'b1; if4.parallel_in = 4'b1011;
    tick();
    if4.load = 1'b0;
    tick();
    tick();
    chk4("pre_async", 1'b1, 1'b1, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk4("async_rst", 1'b0, 1'b0, 1'b0);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk4($sformatf("after_rst%0d", i), 1'b0, 1'b0, 1'b0);
    end

    // LSB-first 8-bit word
    begin
      logic [7:0] exp8;
      exp8 = 8'b1010_0101;
      if8.load = 1'b1; if8.parallel_in = 8'hA5;
      tick();
      if8.load = 1'b0;
      for (int k = 0; k < 8; k++) begin
        chk($sformatf("lsb8_bit%0d", k), 32'(if8.serial_out), 32'(exp8[k]));
        chk($sformatf("lsb8_valid%0d", k), 32'(if8.serial_valid), 32'd1);
        tick();
      end
      chk("lsb8_done_valid", 32'(if8.serial_valid), 32'd0);
      chk("lsb8_done_out", 32'(if8.serial_out), 32'd0);
    end

    // Random traffic against a queue-of-bits model
    q4 = {};
    q8 = {};
    for (int c = 0; c < 400; c++) begin
      logic [3:0] d4;
      logic [7:0] d8;
      logic       l4, l8;
      d4 = 4'($urandom);
      d8 = 8'($urandom);
      l4 = ($urandom_range(0, 5) == 0);
      l8 = ($urandom_range(0, 9) == 0);
      if (rst_n && $urandom_range(0, 60) == 0) begin
        rst_n = 1'b0;
        q4 = {};
        q8 = {};
      end else begin
        rst_n = 1'b1;
      end
      if4.load = l4; if4.parallel_in = d4;
      if8.load = l8; if8.parallel_in = d8;
      tick();
      if (!rst_n) begin
        q4 = {};
        q8 = {};
      end else begin
        if (l4) begin
          q4 = {};
          for (int i = 3; i >= 0; i--) q4.push_back(d4[i]);
        end else if (q4.size() > 0) begin
          void'(q4.pop_front());
        end
        if (l8) begin
          q8 = {};
          for (int i = 0; i < 8; i++) q8.push_back(d8[i]);
        end else if (q8.size() > 0) begin
          void'(q8.pop_front());
        end
      end
      chk4($sformatf("rnd4_%0d", c), (q4.size() > 0) ? q4[0] : 1'b0,
           q4.size() > 0, q4.size() > 1);
      chk($sformatf("rnd8_%0d_out", c), 32'(if8.serial_out),
          32'((q8.size() > 0) ? q8[0] : 1'b0));
      chk($sformatf("rnd8_%0d_valid", c), 32'(if8.serial_valid), 32'(q8.size() > 0));
      chk($sformatf("rnd8_%0d_busy", c), 32'(if8.busy), 32'(q8.size() > 1));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
